control_chain_loader: RTL and testbench

CONTROL_CHAIN_LOADER -- requirements
Module: control_chain_loader

---
 rtl/control_chain_loader_if.sv | 24 ++
 rtl/control_chain_loader.sv | 169 ++++++++++++++++
 tb/tb_control_chain_loader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_chain_loader_if.sv
// Serial control-chain loader bus: load request/word, chain pins and load status.
interface control_chain_loader_if;
    localparam int unsigned WORD_W = 33;

    logic              start;
    logic [WORD_W-1:0] wordIn;
    logic              sdo;
    logic              sclk;
    logic              sdata;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] readback;
    logic              readbackMatch;

    modport master (
        output start, wordIn, sdo,
        input  sclk, sdata, busy, done, readback, readbackMatch
    );

    modport slave (
        input  start, wordIn, sdo,
        output sclk, sdata, busy, done, readback, readbackMatch
    );
endinterface

// File: rtl/control_chain_loader.sv
// Programs a 33-position control chain MSB first over sclk/sdata and captures
// the previous chain contents returned on sdo, comparing them with the last word loaded.
module control_chain_loader #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    control_chain_loader_if.slave bus
);
    localparam int unsigned WORD_W = 33;
    localparam int unsigned PH_W   = 8;
    localparam int unsigned BIT_W  = 6;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state,        w_state_nxt;
    logic [PH_W-1:0]   r_phase,        w_phase_nxt;
    logic [BIT_W-1:0]  r_bit,          w_bit_nxt;
    logic [WORD_W-2:0] r_shift,        w_shift_nxt;
    logic [WORD_W-1:0] r_word,         w_word_nxt;
    logic [WORD_W-1:0] r_readback,     w_readback_nxt;
    logic [WORD_W-1:0] r_shadow,       w_shadow_nxt;
    logic              r_shadow_valid, w_shadow_valid_nxt;
    logic              r_match,        w_match_nxt;
    logic              r_hold,         w_hold_nxt;
    logic              r_sclk,         w_sclk_nxt;
    logic              r_sdata,        w_sdata_nxt;
    logic              r_busy,         w_busy_nxt;
    logic              r_done,         w_done_nxt;
    logic              w_phase_end;
    logic              w_load;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_word         <= '0;
            r_readback     <= '0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_match        <= 1'b0;
            r_hold         <= 1'b0;
            r_sclk         <= 1'b0;
            r_sdata        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_bit          <= w_bit_nxt;
            r_shift        <= w_shift_nxt;
            r_word         <= w_word_nxt;
            r_readback     <= w_readback_nxt;
            r_shadow       <= w_shadow_nxt;
            r_shadow_valid <= w_shadow_valid_nxt;
            r_match        <= w_match_nxt;
            r_hold         <= w_hold_nxt;
            r_sclk         <= w_sclk_nxt;
            r_sdata        <= w_sdata_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase;
        w_bit_nxt          = r_bit;
        w_shift_nxt        = r_shift;
        w_word_nxt         = r_word;
        w_readback_nxt     = r_readback;
        w_shadow_nxt       = r_shadow;
        w_shadow_valid_nxt = r_shadow_valid;
        w_match_nxt        = r_match;
        w_hold_nxt         = r_hold;
        w_sclk_nxt         = r_sclk;
        w_sdata_nxt        = r_sdata;
        w_busy_nxt         = r_busy;
        w_done_nxt         = 1'b0;
        w_phase_end        = (r_phase == PH_LAST);
        w_load             = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_load = bus.start;
            end

            S_LOW: begin
                if (!bus.start) begin
                    w_hold_nxt = 1'b0;
                end
                if (w_phase_end) begin
                    w_state_nxt = S_HIGH;
                    w_phase_nxt = '0;
                    w_sclk_nxt  = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            S_HIGH: begin
                if (!bus.start) begin
                    w_hold_nxt = 1'b0;
                end
                if (w_phase_end) begin
                    w_phase_nxt    = '0;
                    w_sclk_nxt     = 1'b0;
                    w_readback_nxt = {r_readback[WORD_W-2:0], bus.sdo};
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_sdata_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOW;
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_sdata_nxt = r_shift[WORD_W-2];
                        w_shift_nxt = {r_shift[WORD_W-3:0], 1'b0};
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            S_DONE: begin
                w_shadow_nxt       = r_word;
                w_shadow_valid_nxt = 1'b1;
                w_match_nxt        = r_shadow_valid && (r_readback == r_shadow);
                w_state_nxt        = S_IDLE;
                // Only a start held through the whole load chains straight into the next one.
                w_load             = bus.start && r_hold;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt = S_LOW;
            w_word_nxt  = bus.wordIn;
            w_shift_nxt = bus.wordIn[WORD_W-2:0];
            w_sdata_nxt = bus.wordIn[WORD_W-1];
            w_sclk_nxt  = 1'b0;
            w_phase_nxt = '0;
            w_bit_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_hold_nxt  = 1'b1;
        end
    end

    assign bus.sclk          = r_sclk;
    assign bus.sdata         = r_sdata;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.readback      = r_readback;
    assign bus.readbackMatch = r_match;

endmodule

// File: tb/tb_control_chain_loader.sv
// Bench for control_chain_loader: external 34-flop chain models, a timeline-based
// reference for the CLK_DIV=2 instance, and directed literal checks for both instances.
module tb_control_chain_loader;
    localparam int D0 = 2;
    localparam int D1 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    control_chain_loader_if bus0();
    control_chain_loader_if bus1();

    control_chain_loader #(.CLK_DIV(D0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    control_chain_loader #(.CLK_DIV(D1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Chain models: 33 positions plus a dataOut flop; position 20 of chain 0 can be flipped.
    logic [32:0] c0_pos  = '0;
    logic        c0_out  = 1'b0;
    logic        c0_flip = 1'b0;
    logic [32:0] c1_pos  = '0;
    logic        c1_out  = 1'b0;
    int          c0_edges    = 0;
    int          c0_busy_cyc = 0;

    always @(posedge bus0.sclk or posedge c0_flip) begin
        if (c0_flip) begin
            c0_pos[20] <= ~c0_pos[20];
        end else begin
            c0_out <= c0_pos[32];
            c0_pos <= {c0_pos[31:0], bus0.sdata};
        end
    end

    always @(posedge bus1.sclk) begin
        c1_out <= c1_pos[32];
        c1_pos <= {c1_pos[31:0], bus1.sdata};
    end

    assign bus0.sdo = c0_out;
    assign bus1.sdo = c1_out;

    always @(posedge bus0.sclk) c0_edges <= c0_edges + 1;
    always @(negedge clk) if (bus0.busy === 1'b1) c0_busy_cyc <= c0_busy_cyc + 1;

    // Reference for instance 0: m_t is the cycle index within a load (-1 when not loading).
    int          m_t      = -1;
    logic        m_done   = 1'b0;
    logic        m_hold   = 1'b0;
    logic        m_svalid = 1'b0;
    logic        m_match  = 1'b0;
    logic [32:0] m_word   = '0;
    logic [32:0] m_old    = '0;
    logic [32:0] m_shadow = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t      <= -1;
            m_done   <= 1'b0;
            m_hold   <= 1'b0;
            m_svalid <= 1'b0;
            m_match  <= 1'b0;
            m_shadow <= '0;
        end else if (m_done) begin
            m_done   <= 1'b0;
            m_shadow <= m_word;
            m_svalid <= 1'b1;
            m_match  <= m_svalid && (m_old == m_shadow);
            if (m_hold && bus0.start) begin
                m_t    <= 0;
                m_word <= bus0.wordIn;
                m_old  <= c0_pos;
            end
        end else if (m_t >= 0) begin
            if (!bus0.start) m_hold <= 1'b0;
            if (m_t == 66 * D0 - 1) begin
                m_t    <= -1;
                m_done <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (bus0.start) begin
            m_t    <= 0;
            m_word <= bus0.wordIn;
            m_old  <= c0_pos;
            m_hold <= 1'b1;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk33(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_loop();
        int   bi;
        logic exp_sclk;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m_t >= 0) begin
                    bi       = 32 - m_t / (2 * D0);
                    exp_sclk = ((m_t / D0) % 2) == 1;
                    chk1("cyc_busy", bus0.busy, 1'b1);
                    chk1("cyc_done", bus0.done, 1'b0);
                    chk1("cyc_sclk", bus0.sclk, exp_sclk);
                    chk1("cyc_sdata", bus0.sdata, m_word[6'(bi)]);
                end else begin
                    chk1("cyc_busy", bus0.busy, 1'b0);
                    chk1("cyc_sclk", bus0.sclk, 1'b0);
                    chk1("cyc_sdata", bus0.sdata, 1'b0);
                    chk1("cyc_done", bus0.done, m_done);
                end
                if (m_done) chk33("cyc_readback", bus0.readback, m_old);
                chk1("cyc_match", bus0.readbackMatch, m_match);
            end
        end
    endtask

    task automatic wait_done0(input string name);
        int n;
        n = 0;
        while (bus0.done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: done not seen within 2000 cycles, got done=%b expected 1", name, bus0.done);
        end
    endtask

    task automatic load0(input logic [32:0] w, input string name);
        @(posedge clk); #1;
        bus0.wordIn = w;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start  = 1'b0;
        bus0.wordIn = ~w;
        wait_done0(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, b, n, hi, lo;
        fork
            cmp_loop();
        join_none
        bus0.start  = 1'b1;
        bus0.wordIn = 33'h1_2345_6789;
        bus1.start  = 1'b0;
        bus1.wordIn = '0;
        #1;
        chk1("rst_sclk", bus0.sclk, 1'b0);
        chk1("rst_sdata", bus0.sdata, 1'b0);
        chk1("rst_busy", bus0.busy, 1'b0);
        chk1("rst_done", bus0.done, 1'b0);
        chk33("rst_readback", bus0.readback, 33'h0);
        chk1("rst_match", bus0.readbackMatch, 1'b0);
        e = c0_edges;
        b = c0_busy_cyc;
        #21 reset = 1'b0;

        // First load, start already high when reset releases.
        @(posedge clk); #1;
        chk1("t1_busy_first_edge", bus0.busy, 1'b1);
        bus0.start  = 1'b0;
        bus0.wordIn = 33'h0_DEAD_BEEF;
        wait_done0("t1_done");
        chk_int("t1_sclk_edges", c0_edges - e, 33);
        chk_int("t1_busy_cycles", c0_busy_cyc - b, 132);
        chk33("t1_chain", c0_pos, 33'h1_2345_6789);
        chk33("t1_readback", bus0.readback, 33'h0);
        @(posedge clk); #1;
        chk1("t1_match", bus0.readbackMatch, 1'b0);

        // Readback of the previous load matches its word.
        load0(33'h0_AAAA_5555, "t2_done_a");
        load0(33'h1_FFFF_0000, "t2_done_b");
        chk33("t2_readback", bus0.readback, 33'h0_AAAA_5555);
        @(posedge clk); #1;
        chk1("t2_match", bus0.readbackMatch, 1'b1);

        // Corrupted chain position between two identical loads.
        load0(33'h1_5555_AAAA, "t3_done_a");
        c0_flip = 1'b1;
        #1 c0_flip = 1'b0;
        load0(33'h1_5555_AAAA, "t3_done_b");
        chk33("t3_readback", bus0.readback, 33'h1_5545_AAAA);
        @(posedge clk); #1;
        chk1("t3_match", bus0.readbackMatch, 1'b0);

        // start pulses mid-load and during done are ignored.
        e = c0_edges;
        @(posedge clk); #1;
        bus0.wordIn = 33'h0_1234_0F0F;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        repeat (49) @(posedge clk);
        #1 bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        wait_done0("t4_done");
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_int("t4_sclk_edges", c0_edges - e, 33);
        chk1("t4_no_extra_load", bus0.busy, 1'b0);

        // Asynchronous reset at the 17th sclk rising edge.
        @(posedge clk); #1;
        bus0.wordIn = 33'h1_FFFF_FFFF;
        bus0.start  = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        e = c0_edges;
        n = 0;
        while ((c0_edges - e) < 17 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("t5_edge17_reached", c0_edges - e, 17);
        chk1("t5_sclk_before", bus0.sclk, 1'b1);
        chk1("t5_sdata_before", bus0.sdata, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("t5_sclk_async", bus0.sclk, 1'b0);
        chk1("t5_sdata_async", bus0.sdata, 1'b0);
        chk1("t5_busy_async", bus0.busy, 1'b0);
        chk33("t5_readback_async", bus0.readback, 33'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        load0(33'h0_0000_0001, "t5_done");
        @(posedge clk); #1;
        chk33("t5_chain", c0_pos, 33'h0_0000_0001);
        chk1("t5_match", bus0.readbackMatch, 1'b0);

        // CLK_DIV=1 with start held: back-to-back loads.
        @(posedge clk); #1;
        bus1.wordIn = 33'h1_0F0F_F0F0;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        chk1("t6_busy_start", bus1.busy, 1'b1);
        bus1.wordIn = 33'h0_3C3C_C3C3;
        hi = 0;
        while (bus1.busy === 1'b1 && hi < 200) begin
            hi++;
            @(posedge clk); #1;
        end
        chk_int("t6_busy_high_1", hi, 66);
        chk1("t6_done_1", bus1.done, 1'b1);
        chk33("t6_chain_1", c1_pos, 33'h1_0F0F_F0F0);
        lo = 0;
        while (bus1.busy === 1'b0 && lo < 10) begin
            lo++;
            @(posedge clk); #1;
        end
        chk_int("t6_busy_low_1", lo, 1);
        hi = 0;
        while (bus1.busy === 1'b1 && hi < 200) begin
            hi++;
            @(posedge clk); #1;
        end
        chk_int("t6_busy_high_2", hi, 66);
        chk33("t6_chain_2", c1_pos, 33'h0_3C3C_C3C3);
        chk33("t6_readback_2", bus1.readback, 33'h1_0F0F_F0F0);
        lo = 0;
        while (bus1.busy === 1'b0 && lo < 10) begin
            lo++;
            @(posedge clk); #1;
        end
        chk_int("t6_busy_low_2", lo, 1);
        chk1("t6_match_2", bus1.readbackMatch, 1'b1);
        bus1.start = 1'b0;

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
